// File: rtl/tb_irq_stimulus_gen.sv
// Bench-side interrupt source: LFSR-randomised or software-triggered level
// interrupts, each held until the core acknowledges it with a matching id.
module tb_irq_stimulus_gen #(
  parameter logic [15:0] MIN_GAP_RST   = 16'd16,
  parameter logic [15:0] GAP_MASK_RST  = 16'h00FF,
  parameter logic [4:0]  ID_MASK_RST   = 5'h1F,
  parameter logic [31:0] LFSR_SEED_RST = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_ack_id_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ASSERT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt;
  logic [4:0]  id_nxt;
  logic [1:0]  mode;
  logic [31:0] lfsr, lfsr_next;
  logic [15:0] min_gap, gap_mask;
  logic [4:0]  id_mask;
  logic [31:0] count;
  logic        err;

  // register write decodes
  logic wr_mode, wr_seed, wr_gap, wr_mask, wr_idm, wr_trig, wr_cnt, wr_stat;
  assign wr_mode = cfg_we_i && (cfg_addr_i == 3'd0);
  assign wr_seed = cfg_we_i && (cfg_addr_i == 3'd1);
  assign wr_gap  = cfg_we_i && (cfg_addr_i == 3'd2);
  assign wr_mask = cfg_we_i && (cfg_addr_i == 3'd3);
  assign wr_idm  = cfg_we_i && (cfg_addr_i == 3'd4);
  assign wr_trig = cfg_we_i && (cfg_addr_i == 3'd5);
  assign wr_cnt  = cfg_we_i && (cfg_addr_i == 3'd6);
  assign wr_stat = cfg_we_i && (cfg_addr_i == 3'd7);

  // handshake and protocol checks
  logic accept, trig_ok, err_set;
  assign accept  = (state == S_ASSERT) && irq_ack_i && (irq_ack_id_i == irq_id_o);
  assign trig_ok = wr_trig && (state == S_IDLE) && (mode == 2'd2);
  assign err_set = (irq_ack_i && (state != S_ASSERT)) ||
                   (irq_ack_i && (state == S_ASSERT) && (irq_ack_id_i != irq_id_o)) ||
                   (wr_trig && !trig_ok);

  // right-shifting Galois LFSR, taps 0x80200003
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & 32'h8020_0003);

  // the interrupt level is the ASSERT state flop itself, so reset drops it at once
  assign irq_o = (state == S_ASSERT);
  assign err_o = err;

  // next-state, gap counter and id selection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = irq_id_o;
    case (state)
      S_IDLE: begin
        if (mode == 2'd1) begin
          cnt_nxt   = {1'b0, min_gap} + {1'b0, lfsr[15:0] & gap_mask};
          state_nxt = S_WAIT;
        end else if (trig_ok) begin
          id_nxt    = cfg_wdata_i[4:0] & id_mask;
          state_nxt = S_ASSERT;
        end
      end
      S_WAIT: begin
        // leaving random mode wins over an expiring gap
        if (wr_mode && (cfg_wdata_i[1:0] != 2'd1)) begin
          state_nxt = S_IDLE;
        end else if (cnt == 17'd0) begin
          id_nxt    = lfsr[4:0] & id_mask;
          state_nxt = S_ASSERT;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_ASSERT: begin
        if (accept) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM, counter and id registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      irq_id_o <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      irq_id_o <= id_nxt;
    end
  end

  // configuration registers and LFSR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode     <= '0;
      lfsr     <= LFSR_SEED_RST;
      min_gap  <= MIN_GAP_RST;
      gap_mask <= GAP_MASK_RST;
      id_mask  <= ID_MASK_RST;
    end else begin
      if (wr_mode) mode     <= cfg_wdata_i[1:0];
      if (wr_gap)  min_gap  <= cfg_wdata_i[15:0];
      if (wr_mask) gap_mask <= cfg_wdata_i[15:0];
      if (wr_idm)  id_mask  <= cfg_wdata_i[4:0];
      if (wr_seed) lfsr     <= (cfg_wdata_i == 32'd0) ? 32'd1 : cfg_wdata_i;
      else         lfsr     <= lfsr_next;
    end
  end

  // completed-ack counter (a write wins) and sticky error (a new error wins)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (wr_cnt)      count <= '0;
      else if (accept) count <= count + 32'd1;
      if (err_set)                       err <= 1'b1;
      else if (wr_stat && cfg_wdata_i[0]) err <= 1'b0;
    end
  end

  // combinational read mux
  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      3'd0: cfg_rdata_o = {30'd0, mode};
      3'd1: cfg_rdata_o = lfsr;
      3'd2: cfg_rdata_o = {16'd0, min_gap};
      3'd3: cfg_rdata_o = {16'd0, gap_mask};
      3'd4: cfg_rdata_o = {27'd0, id_mask};
      3'd5: cfg_rdata_o = '0;
      3'd6: cfg_rdata_o = count;
      3'd7: cfg_rdata_o = {28'd0, state, irq_o, err};
      default: cfg_rdata_o = '0;
    endcase
  end

endmodule

// File: doc/tb_irq_stimulus_gen.md
Name: tb_irq_stimulus_gen

Overview:
- Bench-side interrupt source that drives the core's irq_i/irq_id_i and consumes its irq_ack_o/irq_id_o.
- Sits directly upstream of the core interrupt controller in tb_riscv_core.
- Generates LFSR-randomised or software-triggered level interrupts, each held until a matching acknowledge.
- Configured through a small word-addressed register port that the core or the bench writes.

Parameters:
- MIN_GAP_RST, 16: reset value of MIN_GAP register (cycles).
- GAP_MASK_RST, 16'h00FF: reset value of GAP_MASK register.
- ID_MASK_RST, 5'h1F: reset value of ID_MASK register.
- LFSR_SEED_RST, 32'h0000_0001: LFSR value after reset.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_we_i  in  1  register write strobe.
- cfg_addr_i  in  3  register word index.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, combinational from cfg_addr_i.
- irq_o  out  1  level interrupt to core irq_i.
- irq_id_o  out  5  interrupt id to core irq_id_i.
- irq_ack_i  in  1  core irq_ack_o.
- irq_ack_id_i  in  5  core irq_id_o.
- err_o  out  1  sticky protocol error.

Behaviour:
- One clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - irq_o=0, irq_id_o=0, err_o=0, state IDLE, COUNT=0.
  - LFSR=LFSR_SEED_RST, MODE=0.
  - MIN_GAP, GAP_MASK, ID_MASK = their *_RST parameters.
- Registers (index: field):
  - 0 MODE[1:0]: 0 off, 1 random, 2 directed, 3 treated as off.
  - 1 SEED[31:0]: a write loads the LFSR; a value of 0 is loaded as 1.
  - 2 MIN_GAP[15:0].
  - 3 GAP_MASK[15:0].
  - 4 ID_MASK[4:0].
  - 5 TRIGGER: write-only; wdata[4:0] is the id; reads 0.
  - 6 COUNT[31:0]: completed acks; a write clears it; wraps at 2^32.
  - 7 STATUS: bit0 err, bit1 irq_o, bits[3:2] state; a write with bit0=1 clears err. Clear has priority only if no new error occurs in the same cycle.
- LFSR:
  - 32-bit Galois, polynomial 0x80200003.
  - Shifts every cycle except the cycle SEED is written.
- FSM states:
  - IDLE=0
  - WAIT=1, with 17-bit down-counter cnt.
  - ASSERT=2
- IDLE:
  - MODE=1: cnt <= MIN_GAP + (lfsr[15:0] & GAP_MASK), unsigned 17-bit; go to WAIT.
  - MODE=2: TRIGGER write -> ASSERT next cycle, irq_id_o <= wdata[4:0] & ID_MASK.
  - MODE=2: any other cycle -> stay in IDLE.
  - Other modes: stay in IDLE.
- WAIT:
  - cnt>0: decrement.
  - cnt==0: go to ASSERT; irq_id_o <= lfsr[4:0] & ID_MASK.
  - MODE write to a value other than 1: abort to IDLE next cycle, no interrupt.
- ASSERT:
  - irq_o=1 (registered); irq_id_o stable.
  - Accept when irq_ack_i && irq_ack_id_i==irq_id_o.
  - On accept: next cycle irq_o=0, COUNT+1, state IDLE.
  - MODE changes do not drop irq_o; the interrupt stays held until accept.
- Errors (set err):
  - irq_ack_i with mismatched id in ASSERT; state remains ASSERT.
  - irq_ack_i in IDLE or WAIT.
  - TRIGGER write while not IDLE, or while MODE!=2; the write is ignored.
- Timing:
  - Random mode: ack-accept cycle t -> irq_o rises at t + MIN_GAP + r + 3, where r = masked LFSR value.
  - Directed mode: trigger write at cycle t -> irq_o=1 at t+1.
- Simultaneous events:
  - Ack accept and MODE write in the same cycle: the ack completes and the new MODE applies from IDLE.
  - Ack accept and COUNT write in the same cycle: COUNT=0, the write wins.
- Reset mid-operation: irq_o drops asynchronously; all registers return to reset values.

Test Plan:
- Reset during ASSERT (irq_o=1) -> irq_o=0, err_o=0, COUNT=0, STATUS=0 immediately; MODE reads 0.
- MODE=2, TRIGGER wdata=0x17, ID_MASK=0x1F -> irq_o=1, irq_id_o=0x17 next cycle. Hold with no ack for 50 cycles -> still asserted. Ack id 0x17 -> irq_o=0 next cycle, COUNT=1.
- MODE=1, MIN_GAP=0, GAP_MASK=0 -> irq_o rises exactly 3 cycles after each accepted ack. 10 acks -> COUNT=10.
- MODE=1, SEED=0 -> LFSR loads 1. MIN_GAP=4, GAP_MASK=0x7 -> every gap lies in [7,14] cycles. Ids always obey ID_MASK=0x03, i.e. ids 0..3.
- In ASSERT with id 5, ack with id 6 -> err_o=1, irq_o stays 1. Ack with id 5 -> released. Write STATUS=1 -> err_o=0.
- MODE=1 in WAIT, write MODE=0 -> IDLE next cycle, irq_o never asserts. TRIGGER written while in ASSERT -> ignored, err_o=1.
